// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches and
// buffers in-order responses in a small FIFO that feeds decode.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        valid
);

  localparam int          CW  = $clog2(FIFO_DEPTH + 1);
  localparam int          PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] occupancy;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   fifo_word [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];

  logic          pop;
  logic          push;
  logic          req_fire;
  logic          resp_live;
  logic [CW:0]   inflight;
  logic [31:0]   redirect_target;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  assign valid       = (occupancy != '0);
  assign instruction = valid ? fifo_word[rd_ptr] : NOP;
  assign pc          = valid ? fifo_pc[rd_ptr] : 32'h0;

  assign pop = valid && !stall && !redirect;

  // Credits count words in flight plus words buffered, so a response always
  // finds a free slot. pop implies occupancy >= 1, so this cannot underflow.
  assign inflight       = {1'b0, outstanding} + {1'b0, occupancy} - {{CW{1'b0}}, pop};
  assign imem_req_valid = rst && !redirect && (inflight < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding belong to pre-reset requests; ignore them.
  assign resp_live = imem_resp_valid && (outstanding != '0);
  assign push      = resp_live && (drop_cnt == '0) && !redirect;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      occupancy   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect) begin
      // Everything still in flight is stale, including a word arriving now.
      fetch_pc    <= redirect_target;
      resp_pc     <= redirect_target;
      outstanding <= outstanding - CW'(resp_live);
      drop_cnt    <= outstanding - CW'(resp_live);
      occupancy   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_live);
      if (resp_live && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      // resp_pc tracks the pc of the next kept response, so no tag queue is needed.
      if (push) begin
        wr_ptr  <= ptr_inc(wr_ptr);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      occupancy <= occupancy + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      fifo_word[wr_ptr] <= imem_resp_data;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: behavioural memory returns the
// request address as data, so every delivered word must equal its pc.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        valid;

  int checks   = 0;
  int failures = 0;

  instruction_fetch_stage #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .instruction     (instruction),
    .pc              (pc),
    .valid           (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Behavioural memory with configurable fixed latency.
  int          lat = 1;
  int          cyc = 0;
  int          issued = 0;
  int          overflow = 0;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  always @(posedge clk) begin
    if (rst && imem_resp_valid && !redirect && dut.drop_cnt == 0 &&
        dut.outstanding != 0 && int'(dut.occupancy) == 2)
      overflow++;
    if (!rst) begin
      q_addr.delete();
      q_due.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= 32'h0;
      issued = 0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        q_addr.push_back(imem_req_addr);
        q_due.push_back(cyc + lat);
        issued++;
      end
      if (q_addr.size() > 0 && q_due[0] <= cyc + 1) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= q_addr.pop_front();
        void'(q_due.pop_front());
      end else begin
        imem_resp_valid <= 1'b0;
      end
    end
    cyc++;
  end

  // Stream monitor: every pop must carry the next expected pc and data == pc;
  // a pending request must keep its address until accepted or redirected.
  logic        mon_en = 1'b0;
  logic [31:0] exp_next = 32'h0;
  int          popped = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_addr = 32'h0;

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      popped = 0;
    end else if (valid && !stall && !redirect) begin
      popped++;
      if (mon_en) begin
        checks++;
        if (pc !== exp_next || instruction !== pc) begin
          failures++;
          $display("FAIL stream_pop got pc=%h instr=%h want pc=%h", pc, instruction, exp_next);
        end
        exp_next = exp_next + 32'd4;
      end
    end
    if (rst && hold_pend && !redirect) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== hold_addr) begin
        failures++;
        $display("FAIL req_hold got valid=%b addr=%h want valid=1 addr=%h",
                 imem_req_valid, imem_req_addr, hold_addr);
      end
    end
    hold_pend = rst && imem_req_valid && !imem_req_ready;
    hold_addr = imem_req_addr;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic cycle_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect = 1'b0; stall = 1'b0; imem_req_ready = 1'b1;
    redirect_pc = 32'h0; lat = 1; mon_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_next = 32'h100;
    mon_en = 1'b1;
    #1;
  endtask

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
  } redir_vec_t;

  redir_vec_t vecs [4];

  initial begin
    vecs[0] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_0044};
    vecs[1] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
    vecs[3] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0004};

    // Reset values and first fetches.
    do_reset();
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    release_reset();
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h100);
    chk("first_valid_c0", {31'b0, valid}, 32'h0);
    cycle_sample();
    chk("first_valid_c1", {31'b0, valid}, 32'h0);
    chk("second_req_addr", imem_req_addr, 32'h104);
    cycle_sample();
    chk("first_out_valid", {31'b0, valid}, 32'h1);
    chk("first_out_pc", pc, 32'h100);
    chk("first_out_instr", instruction, 32'h100);
    cycle_sample();
    chk("out_pc_104", pc, 32'h104);
    cycle_sample();
    chk("out_pc_108", pc, 32'h108);

    // Stall for 5 cycles mid-stream.
    @(negedge clk);
    stall = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_pc", pc, 32'h10C);
      chk("stall_valid", {31'b0, valid}, 32'h1);
      chk("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
      chk("stall_inflight_le2", {31'b0, (issued - popped) <= 2}, 32'h1);
      cycle_sample();
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk("unstall_pc0", pc, 32'h10C);
    cycle_sample();
    chk("unstall_pc1", pc, 32'h110);
    cycle_sample();
    chk("unstall_pc2", pc, 32'h114);
    cycle_sample();
    chk("unstall_pc3", pc, 32'h118);

    // 3-cycle memory, redirect with two requests outstanding.
    do_reset();
    lat = 3;
    release_reset();
    cycle_sample();
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    exp_next = 32'h40;
    #1;
    chk("lat3_redir_no_req", {31'b0, imem_req_valid}, 32'h0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    begin
      int n = 0;
      while (!valid && n < 20) begin
        cycle_sample();
        n++;
      end
    end
    chk("lat3_valid", {31'b0, valid}, 32'h1);
    chk("lat3_pc", pc, 32'h40);
    chk("lat3_instr", instruction, 32'h40);

    // Redirect in the same cycle as a response, with stall asserted.
    do_reset();
    release_reset();
    cycle_sample();
    cycle_sample();
    @(negedge clk);
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    exp_next = 32'h200;
    #1;
    chk("rs_resp_in_redir", {31'b0, imem_resp_valid}, 32'h1);
    @(negedge clk);
    stall = 1'b0;
    redirect = 1'b0;
    #1;
    chk("rs_valid_r1", {31'b0, valid}, 32'h0);
    chk("rs_req_addr_r1", imem_req_addr, 32'h200);
    cycle_sample();
    chk("rs_valid_r2", {31'b0, valid}, 32'h0);
    cycle_sample();
    chk("rs_valid_r3", {31'b0, valid}, 32'h1);
    chk("rs_pc_r3", pc, 32'h200);

    // Random request back-pressure.
    do_reset();
    release_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      imem_req_ready = 1'($urandom_range(0, 1));
    end
    chk("ready_toggle_progress", {31'b0, popped > 40}, 32'h1);
    @(negedge clk);
    imem_req_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Redirect target table, including wrap at the top of the address space.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      redirect = 1'b1;
      redirect_pc = vecs[v].target;
      exp_next = vecs[v].exp_a0;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      chk("redir_valid_r1", {31'b0, valid}, 32'h0);
      chk("redir_req_valid_r1", {31'b0, imem_req_valid}, 32'h1);
      chk("redir_req_addr0", imem_req_addr, vecs[v].exp_a0);
      cycle_sample();
      chk("redir_req_addr1", imem_req_addr, vecs[v].exp_a1);
      cycle_sample();
      chk("redir_out_pc0", pc, vecs[v].exp_a0);
      chk("redir_out_instr0", instruction, vecs[v].exp_a0);
      cycle_sample();
      chk("redir_out_pc1", pc, vecs[v].exp_a1);
      repeat (2) @(negedge clk);
    end

    // Reset asserted mid-stream.
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("midrst_req_valid_now", {31'b0, imem_req_valid}, 32'h0);
    cycle_sample();
    chk("midrst_valid", {31'b0, valid}, 32'h0);
    chk("midrst_instr", instruction, 32'h0000_0013);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    release_reset();
    chk("midrst_first_addr", imem_req_addr, 32'h100);
    repeat (4) @(negedge clk);

    chk("fifo_overflow_events", overflow, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Front end of the five-stage pipeline: owns the program counter, issues word fetches to instruction memory over a valid/ready request channel, buffers returned words in a small FIFO, and presents one `instruction_t` plus its PC per cycle to the decode stage. It applies stalls from the hazard unit and branch/jump redirects from execute. Responses still in flight when a redirect occurs are discarded.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 2, fetch-buffer entries (≥2); also the cap on outstanding requests plus buffered words

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-low
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word-aligned fetch address
- `imem_resp_valid`  in  1  response word valid; in-order, never back-pressured
- `imem_resp_data`  in  32  fetched instruction word
- `stall`  in  1  decode cannot accept; hold output
- `redirect`  in  1  taken branch/jump; flush and refetch
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (treated as 00)
- `instruction`  out  32  `instruction_t` to decode; NOP 32'h0000_0013 when `valid`=0
- `pc`  out  32  PC of `instruction`; 0 when `valid`=0
- `valid`  out  1  `instruction`/`pc` meaningful

## Operation
- State: `fetch_pc` (32b), `outstanding` and `drop_cnt` (clog2(FIFO_DEPTH+1) b), FIFO of {word, pc}, wr/rd pointers, occupancy.
- Pop = `valid && !stall && !redirect`.
- Issue: `imem_req_valid` = `!redirect && (outstanding + occupancy − pop) < FIFO_DEPTH`, with `imem_req_addr` = `fetch_pc`. On handshake, `fetch_pc` += 4 and `outstanding` +1.
- Response: `outstanding` −1.
  - If `drop_cnt`>0: decrement `drop_cnt` and discard the word.
  - Otherwise push {data, pc}. The stored pc comes from a pc-tag queue written at issue, or from an equivalent counter.
- Credit rule guarantees a response always has a free FIFO slot. Push when full is impossible, and the bench asserts this.
- `instruction`/`pc`/`valid` are driven from the FIFO head (registered storage, no combinational path from `imem_resp_*`).
- Redirect (priority over `stall`, pop and issue):
  - FIFO cleared.
  - `fetch_pc` ← {`redirect_pc`[31:2], 2'b00}.
  - `drop_cnt` ← `outstanding` − (`imem_resp_valid` ? 1 : 0). A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle.
- Redirect while `drop_cnt`>0: reload `drop_cnt` by the same formula. Previously pending drops are covered because they are still counted in `outstanding`.
- PC wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Reset (`rst`=0 at an edge):
  - `fetch_pc` ← RESET_PC.
  - FIFO empty; `outstanding`, `drop_cnt` ← 0.
  - Outputs: `valid`=0, `instruction`=NOP, `pc`=0, `imem_req_valid`=0 while `rst`=0.
  - Memory responses to pre-reset requests are the memory's responsibility to cancel; the stage does not count them.

## Timing
- Memory with `imem_req_ready`=1 and 1-cycle response: request in cycle n, response in n+1, `valid` in n+2.
- Sustained throughput is 1 instruction/cycle with FIFO_DEPTH=2 while `stall`=0.
- First request is in the first cycle with `rst`=1.
- Redirect asserted in cycle r: `valid`=0 from r+1, target request in r+1, target instruction valid in r+3 (1-cycle memory, no stale drops pending).
- Stall: outputs hold stable, and at most FIFO_DEPTH words can be in flight or buffered. After the buffer fills, `imem_req_valid` stays 0 until a pop.
- Stall and redirect in the same cycle: the redirect wins.
- `imem_req_addr` holds stable while `imem_req_valid`=1 and `imem_req_ready`=0. Redirect is the only event that may withdraw the request.

## Test plan
- Reset with RESET_PC=32'h100, 1-cycle memory returning `addr`: first request addr 0x100 in the first cycle out of reset; `valid` 2 cycles later with pc=0x100; consecutive cycles give pc 0x104, 0x108.
- `stall` held 5 cycles mid-stream: output frozen at the same pc; no more than 2 requests outstanding or buffered; on release, pc continues +4 with no skip or duplicate.
- Memory with 3-cycle latency and 2 requests outstanding, `redirect` to 0x40: both stale responses dropped; next `valid` has pc=0x40 and data from 0x40.
- Redirect in the same cycle as a response, plus `stall`=1: response discarded, FIFO cleared, next valid pc = target.
- `imem_req_ready` toggling randomly: address held while waiting; delivered pc sequence is strictly +4; FIFO never overflows.
- Redirect to 32'hFFFF_FFFE: fetch at 0xFFFF_FFFC, then 0x0000_0000. `rst` asserted mid-stream: all outputs reach reset values at the next edge.
